// File: rtl/accumulator_4bit.sv
// accumulator_4bit
//   Sums COUNT unsigned 4-bit operands into an 8-bit result, then holds the
//   result until the consumer takes it.
//   Ports:
//     clk          clock, all state updates on the rising edge
//     rst          synchronous active-high reset
//     in_data      unsigned operand
//     in_valid     in_data is valid this cycle
//     in_ready     block accepts in_data this cycle
//     out_sum      accumulator value (partial sum while accumulating)
//     out_overflow sticky flag: some accepted operand wrapped the sum past 255
//     out_valid    out_sum/out_overflow hold a finished result
//     out_ready    consumer takes the result this cycle

// 4-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[4];
endmodule

module accumulator_4bit #(
  parameter int COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_sum,
  output logic       out_overflow,
  output logic       out_valid,
  input  logic       out_ready
);
  typedef enum logic {ACCUM, DONE} state_e;

  // Counter value held while the final operand of a run is being accepted.
  localparam logic [4:0] LAST = 5'(COUNT - 1);

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [4:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;

  logic [3:0] sum_lo, sum_hi;
  logic       c_lo, c_hi;

  // Operand is zero-extended: the high nibble only absorbs the low carry,
  // so its carry-out is exactly the mod-256 wrap.
  ripple_carry_adder_4bit u_add_lo (
    .a_i    (acc_q[3:0]),
    .b_i    (in_data),
    .cin_i  (1'b0),
    .sum_o  (sum_lo),
    .cout_o (c_lo)
  );

  ripple_carry_adder_4bit u_add_hi (
    .a_i    (acc_q[7:4]),
    .b_i    (4'd0),
    .cin_i  (c_lo),
    .sum_o  (sum_hi),
    .cout_o (c_hi)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    // in_ready is forced high during reset; the operand is still dropped
    // because reset wins in the register process.
    in_ready  = (state_q == ACCUM) | rst;
    out_valid = (state_q == DONE);
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = {sum_hi, sum_lo};
          cnt_d = cnt_q + 5'd1;
          if (c_hi)
            ovf_d = 1'b1;
          if (cnt_q == LAST)
            state_d = DONE;
        end
      end
      DONE: begin
        // Handoff: clear everything and accept again on the next cycle.
        // Any in_valid here is ignored.
        if (out_ready) begin
          acc_d   = 8'd0;
          cnt_d   = 5'd0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= 8'd0;
      cnt_q   <= 5'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;
endmodule

// File: doc/accumulator_4bit.md
ACCUMULATOR_4BIT -- requirements
Module: accumulator_4bit

Interface
REQ-001 The block SHALL have parameter COUNT, default 4: number of operands summed per result; legal range 1..31.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, 4 bits: unsigned operand.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 The block SHALL have port out_sum, output, 8 bits: accumulated result.
REQ-008 The block SHALL have port out_overflow, output, 1 bit: the result wrapped past 255.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_sum/out_overflow are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.

Function
REQ-011 The block SHALL perform all addition with two cascaded ripple_carry_adder_4bit instances: low nibble cin=0, carry_out into high-nibble cin; operand zero-extended to 8 bits.
REQ-012 The block SHALL implement FSM states ACCUM and DONE, with reset state ACCUM.
REQ-013 In ACCUM the block SHALL drive in_ready=1 and out_valid=0.
REQ-014 In DONE the block SHALL drive in_ready=0 and out_valid=1.
REQ-015 An operand SHALL be accepted only in a cycle with in_valid=1 and in_ready=1; acc <= acc + in_data (mod 256), and the operand counter increments.
REQ-016 If the high-nibble carry_out is 1 on an accepted operand, the block SHALL set a sticky overflow flag, cleared only on result handoff or reset.
REQ-017 When the COUNT-th operand is accepted, the block SHALL enter DONE on the next edge; out_valid=1 the cycle after that operand's accept cycle (latency 1).
REQ-018 In DONE, out_sum SHALL equal acc and out_overflow SHALL equal the sticky flag, both stable until handoff.
REQ-019 A handoff SHALL occur when out_valid=1 and out_ready=1; on that edge acc, counter and flag clear to 0 and the FSM returns to ACCUM.
REQ-020 Handoff SHALL take effect in one cycle: in_ready=1 in the cycle after handoff, with no bubble beyond that.
REQ-021 in_valid=1 while in DONE (including the handoff cycle) SHALL NOT be accepted and SHALL NOT alter acc.
REQ-022 While out_valid=1 and out_ready=0, the block SHALL hold all outputs unchanged indefinitely.
REQ-023 Counter width SHALL be 5 bits; the counter SHALL wrap to 0 at handoff, never by arithmetic overflow.
REQ-024 out_sum SHALL show acc in ACCUM as well (partial sum); only out_valid qualifies it.

Reset
REQ-025 On a clock edge with rst=1, the block SHALL set state=ACCUM, acc=0, counter=0, flag=0; hence out_sum=0, out_overflow=0, out_valid=0, in_ready=1 the following cycle.
REQ-026 rst SHALL take priority over any simultaneous accept or handoff; a partially accumulated sum SHALL be discarded.
REQ-027 in_ready SHALL be 1 in the cycle during which rst is asserted, but an operand presented then SHALL be discarded.

Verification
REQ-028 COUNT=4, operands 3,5,15,1 back-to-back, out_ready=1 -> out_valid=1 one cycle after the 4th accept, out_sum=0x18, out_overflow=0; in_ready=1 the next cycle.
REQ-029 COUNT=20, twenty operands of 15 -> out_sum=0x2C (300 mod 256), out_overflow=1; after handoff, a new run of 4x1 at COUNT=4 build yields overflow=0.
REQ-030 Backpressure: COUNT=4, sum ready, out_ready=0 for 3 cycles with in_valid=1, in_data=7 -> out_valid and out_sum held, in_ready=0, acc unchanged; handoff on 4th cycle, then 7 accepted as first operand of the next run.
REQ-031 Reset mid-operation: COUNT=4, accept 9,9, assert rst one cycle, then send 1,2,3,4 -> out_sum=0x0A, out_overflow=0.
REQ-032 Gapped input: COUNT=4, operands 2,4,6,8 with in_valid low 1-3 cycles between them -> out_sum=0x14; out_valid only after the 4th accept.
REQ-033 COUNT=1: operand 15 -> out_sum=0x0F the next cycle; repeated handoffs with out_ready=1 each give one result per 2 cycles.
